down_count_monitor: RTL and testbench
=====================================

Name: down_count_monitor

Overview:
- Downstream consumer of the 4-bit synchronous down counter; samples its count output every clock.
- Checks that each sample is exactly previous minus one, modulo 2^WIDTH.
- Locks once the sequence is consistent.
- Reports terminal wrap-arounds (0 -> all-ones) and sequence faults to the lab board / top level.

Parameters:
- WIDTH, 4, width of monitored count.
- WRAP_W, 8, width of wrap-event counter.
- LOCK_N, 2, consecutive valid steps required to enter LOCKED (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- count_in  in  WIDTH  counter output under observation.
- clr  in  1  synchronous clear of wrap_cnt and err.
- locked  out  1  high while FSM in LOCKED.
- wrap_pulse  out  1  one-cycle pulse per detected wrap.
- wrap_cnt  out  WRAP_W  saturating count of wraps.
- err  out  1  sticky fault flag.
- err_pulse  out  1  one-cycle pulse per fault.

Behaviour:
- Reset (rst=0, async): FSM=EMPTY, prev=0, run=0; all outputs 0. Reset mid-operation aborts immediately; the first post-reset sample is treated as fresh.
- prev register captures count_in every clock once out of reset.
- Step definition: step_ok = (count_in == prev - 1 mod 2^WIDTH). A hold (count_in == prev) is a bad step.
- FSM states: EMPTY, ACQ, LOCKED. Encoding is from the shared package.
  - EMPTY: capture count_in, no check; next state ACQ, run=0.
  - ACQ: if step_ok, run++. When run reaches LOCK_N, next state LOCKED. If not step_ok, run=0, stay ACQ, no error.
  - LOCKED: if step_ok, stay. If not step_ok: err_pulse=1, err=1, next state ACQ, run=0.
- Wrap detection: prev==0 and count_in==all-ones in ACQ or LOCKED (never EMPTY).
  - wrap_pulse=1 in the following cycle.
  - wrap_cnt increments, saturating at 2^WRAP_W-1.
- Latency: all outputs registered. The response appears one cycle after the sampling edge.
- locked reflects the registered state, so it rises the cycle after the LOCK_N-th good step.
- clr:
  - Sets wrap_cnt=0 and err=0. Does not affect FSM, prev or pulses.
  - clr with a simultaneous wrap: wrap_cnt=0 (clr wins); wrap_pulse still fires.
  - clr with a simultaneous fault: err=1 (new fault wins over clr); err_pulse fires.
- Width rules: the subtraction is WIDTH bits, with the borrow discarded.

Optional Feature:
- Macro DOWN_COUNT_MON_ERRCNT_EN.
- Defined:
  - Adds output err_cnt [7:0], a saturating count of faults (err_pulse events).
  - Cleared by rst and by clr. Simultaneous clr and fault gives err_cnt=1.
- Undefined: port absent, no extra logic; all other behaviour identical.

Decomposition:
- Shared package down_count_pkg:
  - state typedef (EMPTY, ACQ, LOCKED).
  - localparam for default WIDTH=4.
  - function next_down(x) returning x-1 mod 2^WIDTH; the counter testbench reuses it.
- One natural sub-module: sat_counter (parameter W; inc, clr, rst inputs), instantiated for wrap_cnt and, under the macro, err_cnt.

Test Plan:
- Reset: hold rst=0 with count_in=5 -> all outputs 0. Release, then feed 5,4,3 -> locked=1 the cycle after sample 3 (LOCK_N=2).
- Wrap: locked, feed 1,0,15,14 -> wrap_pulse high exactly one cycle after the 15 sample; wrap_cnt=1; err=0.
- Fault: locked, feed 7,6,9 -> err_pulse one cycle, err stays 1, locked falls. Then 8,7 -> locked=1 again; err remains 1.
- Hold/acquire: feed 3,3,3,2,1 from reset -> no err in ACQ; locked asserts after sample 1.
- Saturation/clr: WRAP_W=2, run 5 full cycles -> wrap_cnt saturates at 3. Assert clr on the same cycle as the 6th wrap -> wrap_cnt=0 and wrap_pulse=1.
- Async reset mid-stream: drop rst between edges while locked -> outputs 0 immediately, without waiting for a clock edge. Next sample after release gets no check.

Source files
------------

// File: rtl/down_count_pkg.sv
// Shared types and helpers for the down-counter and its monitor.
package down_count_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic logic [DEFAULT_WIDTH-1:0] next_down(input logic [DEFAULT_WIDTH-1:0] x);
    return x - 4'd1;
  endfunction

endpackage

// File: rtl/down_count_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; INC_WINS selects whether an
// increment coincident with clr leaves the count at 1 instead of 0.
module sat_counter #(
  parameter int W        = 8,
  parameter bit INC_WINS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // count register: clear, saturating increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= (INC_WINS && inc) ? W'(1) : '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/down_count_monitor.sv
// Watches a free-running down counter, locks onto a consistent sequence and
// reports wraps and sequence faults. DOWN_COUNT_MON_ERRCNT_EN adds err_cnt.
module down_count_monitor
  import down_count_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int WRAP_W = 8,
  parameter int LOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic              err_pulse
`ifdef DOWN_COUNT_MON_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [3:0]       LOCK_V   = 4'(LOCK_N);

  state_t           state_r, state_nxt_s;
  logic [3:0]       run_r, run_nxt_s, run_inc_s;
  logic [WIDTH-1:0] prev_r;
  logic             step_ok_s, fault_s, wrap_s;

  // borrow out of the WIDTH-bit subtraction is dropped, so 0 -> all-ones is a good step
  assign step_ok_s = (count_in == (prev_r - ONE));
  assign run_inc_s = run_r + 4'd1;

  // state, run length and previous sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
      run_r   <= 4'd0;
      prev_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      run_r   <= run_nxt_s;
      prev_r  <= count_in;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    run_nxt_s   = run_r;
    case (state_r)
      ST_EMPTY: begin
        state_nxt_s = ST_ACQ;
        run_nxt_s   = 4'd0;
      end
      ST_ACQ: begin
        if (step_ok_s) begin
          run_nxt_s = run_inc_s;
          if (run_inc_s >= LOCK_V) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_ACQ;
          end
        end else begin
          run_nxt_s   = 4'd0;
          state_nxt_s = ST_ACQ;
        end
      end
      ST_LOCKED: begin
        if (step_ok_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_ACQ;
          run_nxt_s   = 4'd0;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
        run_nxt_s   = 4'd0;
      end
    endcase
  end

  // event decode; a fresh sample in EMPTY is never checked
  always_comb begin
    fault_s = 1'b0;
    wrap_s  = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        fault_s = 1'b0;
        wrap_s  = 1'b0;
      end
      ST_ACQ: begin
        fault_s = 1'b0;
        wrap_s  = (prev_r == '0) && (count_in == ALL_ONES);
      end
      ST_LOCKED: begin
        fault_s = !step_ok_s;
        wrap_s  = (prev_r == '0) && (count_in == ALL_ONES);
      end
      default: begin
        fault_s = 1'b0;
        wrap_s  = 1'b0;
      end
    endcase
  end

  // registered outputs; a new fault overrides clr on err
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      err        <= 1'b0;
    end else begin
      locked     <= (state_nxt_s == ST_LOCKED);
      wrap_pulse <= wrap_s;
      err_pulse  <= fault_s;
      if (fault_s) begin
        err <= 1'b1;
      end else if (clr) begin
        err <= 1'b0;
      end else begin
        err <= err;
      end
    end
  end

  sat_counter #(.W(WRAP_W), .INC_WINS(1'b0)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wrap_s),
    .cnt (wrap_cnt)
  );

`ifdef DOWN_COUNT_MON_ERRCNT_EN
  sat_counter #(.W(8), .INC_WINS(1'b1)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (fault_s),
    .cnt (err_cnt)
  );
`endif

endmodule

// File: tb/tb_down_count_monitor.sv
// Self-checking bench for down_count_monitor: directed table, corner sequences
// and randomized stimulus against a streak-based reference model.
module tb_down_count_monitor;
  import down_count_pkg::*;

  localparam int LOCK_N = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] count_in = 4'd5;
  logic       clr = 1'b0;
  logic       locked, wrap_pulse, err, err_pulse;
  logic [7:0] wrap_cnt;
  logic       locked_w2, wrap_pulse_w2, err_w2, err_pulse_w2;
  logic [1:0] wrap_cnt_w2;
`ifdef DOWN_COUNT_MON_ERRCNT_EN
  logic [7:0] err_cnt, err_cnt_w2;
`endif

  always #5 clk = ~clk;

  down_count_monitor #(.WIDTH(4), .WRAP_W(8), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .clr(clr),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt),
    .err(err), .err_pulse(err_pulse)
`ifdef DOWN_COUNT_MON_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  down_count_monitor #(.WIDTH(4), .WRAP_W(2), .LOCK_N(LOCK_N)) dut_w2 (
    .clk(clk), .rst(rst), .count_in(count_in), .clr(clr),
    .locked(locked_w2), .wrap_pulse(wrap_pulse_w2), .wrap_cnt(wrap_cnt_w2),
    .err(err_w2), .err_pulse(err_pulse_w2)
`ifdef DOWN_COUNT_MON_ERRCNT_EN
    , .err_cnt(err_cnt_w2)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // reference model: a streak of consecutive good steps since the last fresh sample
  bit m_have;
  int m_prev, m_streak, m_wc, m_ecnt;
  bit m_locked, m_wp, m_ep, m_err;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_have = 0; m_prev = 0; m_streak = 0; m_wc = 0; m_ecnt = 0;
    m_locked = 0; m_wp = 0; m_ep = 0; m_err = 0;
  endtask

  task automatic model_update(input int c, input bit cl);
    bit good;
    m_wp = 0;
    m_ep = 0;
    if (!m_have) begin
      m_have = 1;
      m_streak = 0;
    end else begin
      good = (c == (m_prev + 15) % 16);
      m_wp = (m_prev == 0) && (c == 15);
      if (good) m_streak++;
      else begin
        if (m_streak >= LOCK_N) m_ep = 1;
        m_streak = 0;
      end
    end
    m_locked = (m_streak >= LOCK_N);
    if (cl) m_wc = 0;
    else if (m_wp) m_wc++;
    if (m_ep) m_err = 1;
    else if (cl) m_err = 0;
    if (cl) m_ecnt = m_ep ? 1 : 0;
    else if (m_ep) m_ecnt++;
    m_prev = c;
  endtask

  task automatic compare_all();
    check("locked", locked, m_locked);
    check("wrap_pulse", wrap_pulse, m_wp);
    check("err", err, m_err);
    check("err_pulse", err_pulse, m_ep);
    check("wrap_cnt", wrap_cnt, sat(m_wc, 255));
    check("wrap_cnt_w2", wrap_cnt_w2, sat(m_wc, 3));
    check("locked_w2", locked_w2, m_locked);
`ifdef DOWN_COUNT_MON_ERRCNT_EN
    check("err_cnt", err_cnt, sat(m_ecnt, 255));
    check("err_cnt_w2", err_cnt_w2, sat(m_ecnt, 255));
`endif
  endtask

  task automatic step(input logic [3:0] c, input logic cl);
    @(negedge clk);
    rst = 1'b1;
    count_in = c;
    clr = cl;
    @(posedge clk);
    model_update(c, cl);
    #1;
    compare_all();
  endtask

  // asynchronous reset between edges; released by the next step
  task automatic async_reset();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_locked", locked, 0);
    check("rst_wrap_pulse", wrap_pulse, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    check("rst_err", err, 0);
    check("rst_err_pulse", err_pulse, 0);
  endtask

  typedef struct {
    logic [3:0] cnt;
    logic       cl;
    logic       lk;
    logic       wp;
    logic       er;
    logic       ep;
    int         wc;
  } vec_t;

  vec_t tbl [0:17];

  initial begin
    logic [3:0] c;
    logic       cl;
    int         wraps;

    tbl[0]  = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{4'd1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[5]  = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[6]  = '{4'd15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'd7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[9]  = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[10] = '{4'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[11] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[12] = '{4'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    tbl[13] = '{4'd6,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[14] = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0};
    tbl[15] = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    tbl[16] = '{4'd4,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    tbl[17] = '{4'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0};

    // reset held with count_in=5
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_locked", locked, 0);
    check("reset_wrap_pulse", wrap_pulse, 0);
    check("reset_wrap_cnt", wrap_cnt, 0);
    check("reset_err", err, 0);
    check("reset_err_pulse", err_pulse, 0);

    // directed table: lock, wrap, fault, relock, clr, hold fault, clr+fault
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].cnt, tbl[i].cl);
      check($sformatf("tbl%0d_locked", i), locked, tbl[i].lk);
      check($sformatf("tbl%0d_wrap_pulse", i), wrap_pulse, tbl[i].wp);
      check($sformatf("tbl%0d_err", i), err, tbl[i].er);
      check($sformatf("tbl%0d_err_pulse", i), err_pulse, tbl[i].ep);
      check($sformatf("tbl%0d_wrap_cnt", i), wrap_cnt, tbl[i].wc);
    end

    // hold during acquisition is not an error
    async_reset();
    step(4'd3, 1'b0);
    step(4'd3, 1'b0);
    check("hold_acq_err", err_pulse, 0);
    step(4'd3, 1'b0);
    step(4'd2, 1'b0);
    check("hold_acq_locked_early", locked, 0);
    step(4'd1, 1'b0);
    check("hold_acq_locked", locked, 1);
    check("hold_acq_err_flag", err, 0);

    // saturation of the 2-bit wrap counter, then clr on the 6th wrap
    c = 4'd1;
    wraps = 0;
    while (wraps < 6) begin
      c = next_down(c);
      if (c == 4'd15) wraps++;
      cl = (wraps == 6) && (c == 4'd15);
      step(c, cl);
      if (wraps == 5 && c == 4'd15) begin
        check("sat_w2_wrap_cnt", wrap_cnt_w2, 3);
        check("sat_wrap_cnt", wrap_cnt, 5);
      end
    end
    check("clr_wrap_w2_cnt", wrap_cnt_w2, 0);
    check("clr_wrap_cnt", wrap_cnt, 0);
    check("clr_wrap_pulse", wrap_pulse_w2, 1);
    check("clr_wrap_locked", locked, 1);

    // async reset while locked; next sample is fresh
    async_reset();
    step(4'd9, 1'b0);
    check("post_rst_err_pulse", err_pulse, 0);
    check("post_rst_locked", locked, 0);

    // randomized stimulus
    c = 4'd9;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) async_reset();
      if ($urandom_range(7) != 0) c = next_down(c);
      else c = 4'($urandom_range(15));
      cl = ($urandom_range(15) == 0);
      step(c, cl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
